mux_pipe_nx: RTL and testbench

- Parametrised successor to the team's fixed 2-input, 5-bit selector: an N-channel, WIDTH-bit multiplexer with a registered output and valid/ready handshakes on every channel.
- Used in the pipelined datapath, e.g. register-destination and writeback-source selection. A source is consumed only when the downstream stage accepts the result.
- Two modes:
  - MODE=0: external select.
  - MODE=1: round-robin arbitration among valid channels.

---
 rtl/mux_pipe_pkg.sv | 15 +
 rtl/rr_arbiter_n.sv | 28 ++
 rtl/mux_pipe_nx.sv | 98 +++++++++
 tb/tb_mux_pipe_nx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_pkg.sv
// Shared constants and helpers for the N-channel pipelined multiplexer.
package mux_pipe_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin picker: first valid channel at or after i_ptr, wrapping mod N.
module rr_arbiter_n
  import mux_pipe_pkg::*;
#(
  parameter int N  = 2,
  parameter int SW = clog2_min1(N)
) (
  input  logic [SW-1:0] i_ptr,
  input  logic [N-1:0]  i_valid,
  output logic [SW-1:0] o_grant,
  output logic          o_grant_valid
);

  int w_idx;

  always_comb begin
    o_grant       = '0;
    o_grant_valid = |i_valid;
    w_idx         = 0;
    // Walk from the farthest offset back to the pointer so the nearest valid wins.
    for (int off = N - 1; off >= 0; off--) begin
      w_idx = int'(i_ptr) + off;
      if (w_idx >= N) w_idx = w_idx - N;
      if (i_valid[w_idx]) o_grant = SW'(w_idx);
    end
  end

endmodule

// File: rtl/mux_pipe_nx.sv
// N-channel, WIDTH-bit multiplexer with a one-entry registered output slot and
// valid/ready handshakes; channel chosen by S or by round-robin arbitration.
module mux_pipe_nx
  import mux_pipe_pkg::*;
#(
  parameter int N     = 2,
  parameter int WIDTH = 5,
  parameter int MODE  = MUX_MODE_SEL,
  parameter int SW    = clog2_min1(N)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N*WIDTH-1:0] A,
  input  logic [N-1:0]       A_valid,
  output logic [N-1:0]       A_ready,
  input  logic [SW-1:0]      S,
  output logic [WIDTH-1:0]   Y,
  output logic               Y_valid,
  input  logic               Y_ready,
  output logic [SW-1:0]      Y_sel
);

  logic             w_can_load;
  logic             w_xfer;
  logic             w_grant_valid;
  logic [SW-1:0]    w_grant;
  logic [WIDTH-1:0] w_data;

  logic [WIDTH-1:0] r_y;
  logic             r_y_valid;
  logic [SW-1:0]    r_y_sel;

  assign w_can_load = !r_y_valid || Y_ready;
  assign w_xfer     = w_can_load && w_grant_valid && !Reset;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SW-1:0] r_ptr;

      rr_arbiter_n #(
        .N  (N),
        .SW (SW)
      ) u_arb (
        .i_ptr         (r_ptr),
        .i_valid       (A_valid),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
      );

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          r_ptr <= '0;
        end else if (w_xfer) begin
          r_ptr <= (w_grant == SW'(N - 1)) ? '0 : w_grant + 1'b1;
        end
      end
    end else begin : g_sel
      // Out-of-range selects (non power-of-two N) never grant.
      always_comb begin
        w_grant       = S;
        w_grant_valid = 1'b0;
        if (int'(S) < N) w_grant_valid = A_valid[S];
      end
    end
  endgenerate

  always_comb begin
    w_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_grant == SW'(k)) w_data = A[k*WIDTH +: WIDTH];
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign A_ready[gi] = w_xfer && (w_grant == SW'(gi));
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_sel   <= '0;
    end else if (w_xfer) begin
      r_y       <= w_data;
      r_y_valid <= 1'b1;
      r_y_sel   <= w_grant;
    end else if (Y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  assign Y       = r_y;
  assign Y_valid = r_y_valid;
  assign Y_sel   = r_y_sel;

endmodule

// File: tb/tb_mux_pipe_nx.sv
// Bench for mux_pipe_nx: external select (N=2, N=3) and round-robin (N=4) instances.
module tb_mux_pipe_nx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [9:0]  a2;
  logic [1:0]  v2, rdy2;
  logic        s2, ys2, yv2, yr2;
  logic [4:0]  y2;

  logic [31:0] a4;
  logic [3:0]  v4, rdy4;
  logic [1:0]  s4, ys4;
  logic [7:0]  y4;
  logic        yv4, yr4;

  logic [14:0] a3;
  logic [2:0]  v3, rdy3;
  logic [1:0]  s3, ys3;
  logic [4:0]  y3;
  logic        yv3, yr3;

  mux_pipe_nx #(.N(2), .WIDTH(5), .MODE(0)) u_dut2 (
    .Clk(clk), .Reset(rst), .A(a2), .A_valid(v2), .A_ready(rdy2), .S(s2),
    .Y(y2), .Y_valid(yv2), .Y_ready(yr2), .Y_sel(ys2)
  );

  mux_pipe_nx #(.N(4), .WIDTH(8), .MODE(1)) u_dut4 (
    .Clk(clk), .Reset(rst), .A(a4), .A_valid(v4), .A_ready(rdy4), .S(s4),
    .Y(y4), .Y_valid(yv4), .Y_ready(yr4), .Y_sel(ys4)
  );

  mux_pipe_nx #(.N(3), .WIDTH(5), .MODE(0)) u_dut3 (
    .Clk(clk), .Reset(rst), .A(a3), .A_valid(v3), .A_ready(rdy3), .S(s3),
    .Y(y3), .Y_valid(yv3), .Y_ready(yr3), .Y_sel(ys3)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] y;
    logic [3:0] sel;
  } exp_t;

  typedef struct {
    logic [4:0] a0;
    logic [4:0] a1;
    logic       s;
    logic [1:0] v;
    logic       yr;
    logic       xfer;
  } vec_t;

  exp_t q2[$];
  exp_t q4[$];
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop2();
    exp_t e;
    if (q2.size() == 0) begin
      check("dut2 scoreboard empty", 32'd1, 32'd0);
    end else begin
      e = q2.pop_front();
      check("dut2 Y", 32'(y2), 32'(e.y));
      check("dut2 Y_sel", 32'(ys2), 32'(e.sel));
      check("dut2 Y_valid", 32'(yv2), 32'd1);
      $display("txn dut2: Y=%h Y_sel=%0d (exp %h/%0d)", y2, ys2, e.y, e.sel);
    end
  endtask

  task automatic pop4();
    exp_t e;
    if (q4.size() == 0) begin
      check("dut4 scoreboard empty", 32'd1, 32'd0);
    end else begin
      e = q4.pop_front();
      check("dut4 Y", 32'(y4), 32'(e.y));
      check("dut4 Y_sel", 32'(ys4), 32'(e.sel));
      check("dut4 Y_valid", 32'(yv4), 32'd1);
      $display("txn dut4: Y=%h Y_sel=%0d (exp %h/%0d)", y4, ys4, e.y, e.sel);
    end
  endtask

  // Called at posedge+1; drives one vector, checks A_ready, then the registered result.
  task automatic step2(input vec_t t);
    exp_t e;
    a2  = {t.a1, t.a0};
    s2  = t.s;
    v2  = t.v;
    yr2 = t.yr;
    #1;
    check("dut2 A_ready", 32'(rdy2), t.xfer ? (t.s ? 32'd2 : 32'd1) : 32'd0);
    if (t.xfer) begin
      e.y   = {3'b000, (t.s ? t.a1 : t.a0)};
      e.sel = {3'b000, t.s};
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
    if (t.xfer) pop2();
    else check("dut2 Y_valid idle", 32'(yv2), 32'd0);
  endtask

  task automatic step4(input int sel);
    exp_t e;
    #1;
    check("dut4 A_ready", 32'(rdy4), 32'(1) << sel);
    e.y   = 8'(8'hA0 + sel);
    e.sel = 4'(sel);
    q4.push_back(e);
    @(posedge clk);
    #1;
    pop4();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_all[5];
    int seq_odd[4];
    logic [4:0] last_y;
    logic       last_s;

    seq_all = '{0, 1, 2, 3, 0};
    seq_odd = '{1, 3, 1, 3};

    tbl[0] = '{a0: 5'b11111, a1: 5'b00000, s: 1'b1, v: 2'b11, yr: 1'b1, xfer: 1'b1};
    tbl[1] = '{a0: 5'b10101, a1: 5'b01010, s: 1'b0, v: 2'b11, yr: 1'b1, xfer: 1'b1};
    tbl[2] = '{a0: 5'b10101, a1: 5'b01010, s: 1'b1, v: 2'b11, yr: 1'b1, xfer: 1'b1};
    tbl[3] = '{a0: 5'h07, a1: 5'h19, s: 1'b1, v: 2'b01, yr: 1'b1, xfer: 1'b0};
    tbl[4] = '{a0: 5'h07, a1: 5'h19, s: 1'b0, v: 2'b01, yr: 1'b1, xfer: 1'b1};
    for (int i = 0; i < 8; i++) begin
      tbl[5+i] = '{a0: 5'(i * 7 + 3), a1: 5'(i * 5 + 17), s: (i % 3 == 0) ? 1'b1 : 1'b0,
                   v: 2'b11, yr: 1'b1, xfer: 1'b1};
    end

    rst = 1'b1;
    a2 = {5'b00000, 5'b11111}; s2 = 1'b1; v2 = 2'b11; yr2 = 1'b1;
    a4 = '0; v4 = '0; s4 = '0; yr4 = 1'b1;
    a3 = '0; v3 = '0; s3 = '0; yr3 = 1'b1;

    #1;
    check("reset Y", 32'(y2), 32'd0);
    check("reset Y_valid", 32'(yv2), 32'd0);
    check("reset Y_sel", 32'(ys2), 32'd0);
    check("reset A_ready", 32'(rdy2), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset held Y_valid", 32'(yv2), 32'd0);
    check("reset held A_ready", 32'(rdy2), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) step2(tbl[i]);

    // Backpressure: hold the last table result for three cycles.
    last_s = tbl[12].s;
    last_y = last_s ? tbl[12].a1 : tbl[12].a0;
    a2 = {5'h11, 5'h0E}; s2 = 1'b0; v2 = 2'b11; yr2 = 1'b0;
    #1;
    check("bp A_ready", 32'(rdy2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp Y hold", 32'(y2), 32'(last_y));
      check("bp Y_sel hold", 32'(ys2), 32'(last_s));
      check("bp Y_valid hold", 32'(yv2), 32'd1);
      check("bp A_ready hold", 32'(rdy2), 32'd0);
    end
    yr2 = 1'b1;
    #1;
    check("bp release A_ready", 32'(rdy2), 32'd1);
    @(posedge clk);
    #1;
    check("bp release Y", 32'(y2), 32'h0E);
    check("bp release Y_sel", 32'(ys2), 32'd0);
    check("bp release Y_valid", 32'(yv2), 32'd1);
    $display("txn dut2: backpressure release Y=%h", y2);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("async rst Y", 32'(y2), 32'd0);
    check("async rst Y_valid", 32'(yv2), 32'd0);
    check("async rst Y_sel", 32'(ys2), 32'd0);
    check("async rst A_ready", 32'(rdy2), 32'd0);
    @(posedge clk);
    #1;
    check("async rst held Y_valid", 32'(yv2), 32'd0);
    rst = 1'b0;
    v2 = 2'b00;

    // Round-robin, all channels valid then only 1 and 3.
    a4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    v4 = 4'b1111;
    for (int i = 0; i < 5; i++) step4(seq_all[i]);
    v4 = 4'b1010;
    for (int i = 0; i < 4; i++) step4(seq_odd[i]);
    v4 = 4'b0000;
    #1;
    check("rr idle A_ready", 32'(rdy4), 32'd0);
    @(posedge clk);
    #1;
    check("rr idle Y_valid", 32'(yv4), 32'd0);

    // Invalid select on a 3-channel instance.
    a3 = {5'h13, 5'h0C, 5'h05};
    v3 = 3'b111; s3 = 2'd2; yr3 = 1'b1;
    #1;
    check("sel3 A_ready ch2", 32'(rdy3), 32'd4);
    @(posedge clk);
    #1;
    check("sel3 Y", 32'(y3), 32'h13);
    check("sel3 Y_sel", 32'(ys3), 32'd2);
    check("sel3 Y_valid", 32'(yv3), 32'd1);
    s3 = 2'd3; yr3 = 1'b0;
    #1;
    check("sel3 S=3 stalled A_ready", 32'(rdy3), 32'd0);
    @(posedge clk);
    #1;
    check("sel3 S=3 Y_valid hold", 32'(yv3), 32'd1);
    yr3 = 1'b1;
    #1;
    check("sel3 S=3 A_ready", 32'(rdy3), 32'd0);
    @(posedge clk);
    #1;
    check("sel3 S=3 Y_valid fall", 32'(yv3), 32'd0);
    check("sel3 S=3 Y hold", 32'(y3), 32'h13);
    check("sel3 S=3 Y_sel hold", 32'(ys3), 32'd2);
    s3 = 2'd0;
    #1;
    check("sel3 A_ready ch0", 32'(rdy3), 32'd1);
    @(posedge clk);
    #1;
    check("sel3 ch0 Y", 32'(y3), 32'h05);
    check("sel3 ch0 Y_sel", 32'(ys3), 32'd0);
    $display("txn dut3: Y=%h Y_sel=%0d", y3, ys3);

    check("dut2 scoreboard drained", 32'(q2.size()), 32'd0);
    check("dut4 scoreboard drained", 32'(q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
